// File: rtl/l3_miss_responder.sv
// L3 miss responder: serves one L2 miss at a time from a direct-mapped,
// word-granular, write-through / write-allocate L3 store. A miss fetches the
// word from main memory, a write is merged and forwarded to memory, and the
// pre-write word goes back to L2 as a one-cycle valid pulse.
module l3_miss_responder #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_LINES  = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  l2_req_i,
  input  logic                  l2_wr_en_i,
  input  logic [ADDR_WIDTH-1:0] l2_addr_i,
  input  logic [DATA_WIDTH-1:0] l2_wr_data_i,
  input  logic [3:0]            l2_byte_en_i,
  output logic                  l3_busy_o,
  output logic                  l3_cache_valid_o,
  output logic [DATA_WIDTH-1:0] l3_cache_data_o,
  output logic                  mem_req_o,
  output logic                  mem_wr_en_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wr_data_o,
  input  logic                  mem_ready_i,
  input  logic [DATA_WIDTH-1:0] mem_rd_data_i
);

  localparam int INDEX_BITS = $clog2(NUM_LINES);
  localparam int TAG_BITS   = ADDR_WIDTH - INDEX_BITS - 2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOOKUP = 3'd1,
    MEM_RD = 3'd2,
    MEM_WR = 3'd3,
    RESP   = 3'd4
  } state_t;

  state_t state;
  state_t state_next;

  // Captured request (word address only; the byte offset is irrelevant)
  logic [ADDR_WIDTH-3:0] req_word;
  logic                  req_wr;
  logic [DATA_WIDTH-1:0] req_data;
  logic [3:0]            req_be;

  // Pre-write word of the current line and the held response word
  logic [DATA_WIDTH-1:0] old_word;
  logic [DATA_WIDTH-1:0] resp_word;

  // Line storage: only the valid bits are reset
  logic [NUM_LINES-1:0]  line_valid;
  logic [TAG_BITS-1:0]   tag_mem  [NUM_LINES];
  logic [DATA_WIDTH-1:0] data_mem [NUM_LINES];

  logic [INDEX_BITS-1:0] index;
  logic [TAG_BITS-1:0]   tag;
  logic                  hit;
  logic                  be_ok;
  logic [DATA_WIDTH-1:0] merged;
  logic                  addr_lsb_unused;

  // Only the three natural lane widths are mergeable; anything else leaves the line alone
  function automatic logic be_supported(input logic [3:0] be);
    return (be == 4'b0001) || (be == 4'b0011) || (be == 4'b1111);
  endfunction

  // Low-lane aligned write data replaces the enabled low bytes of the old word
  function automatic logic [DATA_WIDTH-1:0] merge_word(input logic [DATA_WIDTH-1:0] old,
                                                       input logic [DATA_WIDTH-1:0] wr,
                                                       input logic [3:0]            be);
    logic [DATA_WIDTH-1:0] m;
    m = old;
    case (be)
      4'b0001: m[7:0]  = wr[7:0];
      4'b0011: m[15:0] = wr[15:0];
      4'b1111: m       = wr;
      default: m       = old;
    endcase
    return m;
  endfunction

  assign addr_lsb_unused = ^l2_addr_i[1:0];
  assign index  = req_word[INDEX_BITS-1:0];
  assign tag    = req_word[ADDR_WIDTH-3:INDEX_BITS];
  assign hit    = line_valid[index] && (tag_mem[index] == tag);
  assign be_ok  = be_supported(req_be);
  assign merged = merge_word(old_word, req_data, req_be);

  // State register; async reset aborts any transaction in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:   if (l2_req_i) state_next = LOOKUP;
      LOOKUP: begin
        if (!hit)                 state_next = MEM_RD;
        else if (req_wr && be_ok) state_next = MEM_WR;
        else                      state_next = RESP;
      end
      MEM_RD: if (mem_ready_i) state_next = (req_wr && be_ok) ? MEM_WR : RESP;
      MEM_WR: if (mem_ready_i) state_next = RESP;
      RESP:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded from state; memory outputs are steady for the whole handshake
  always_comb begin
    l3_busy_o        = (state != IDLE);
    l3_cache_valid_o = (state == RESP);
    mem_req_o        = (state == MEM_RD) || (state == MEM_WR);
    mem_wr_en_o      = (state == MEM_WR);
    mem_addr_o       = '0;
    mem_wr_data_o    = '0;
    if (mem_req_o)   mem_addr_o    = {req_word, 2'b00};
    if (mem_wr_en_o) mem_wr_data_o = merged;
  end

  // Request capture, only when a new request is accepted
  always_ff @(posedge clk) begin
    if (state == IDLE && l2_req_i) begin
      req_word <= l2_addr_i[ADDR_WIDTH-1:2];
      req_wr   <= l2_wr_en_i;
      req_data <= l2_wr_data_i;
      req_be   <= l2_byte_en_i;
    end
  end

  // Old word: from the array on a hit, from memory on a fill
  always_ff @(posedge clk) begin
    if (state == LOOKUP)                    old_word <= data_mem[index];
    else if (state == MEM_RD && mem_ready_i) old_word <= mem_rd_data_i;
  end

  // Tag/data array updates on fill and on write handshake
  always_ff @(posedge clk) begin
    if (state == MEM_RD && mem_ready_i) begin
      data_mem[index] <= mem_rd_data_i;
      tag_mem[index]  <= tag;
    end else if (state == MEM_WR && mem_ready_i) begin
      data_mem[index] <= merged;
    end
  end

  // Valid bits set on fill, cleared by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) line_valid <= '0;
    else if (state == MEM_RD && mem_ready_i) line_valid[index] <= 1'b1;
  end

  // Response word loaded on entry to RESP and held until the next response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_word <= '0;
    end else if (state_next == RESP && state != RESP) begin
      if (state == LOOKUP)      resp_word <= data_mem[index];
      else if (state == MEM_RD) resp_word <= mem_rd_data_i;
      else                      resp_word <= old_word;
    end
  end

  assign l3_cache_data_o = resp_word;

endmodule

// File: tb/tb_l3_miss_responder.sv
// Self-checking bench for l3_miss_responder: directed scenarios plus random
// traffic compared against a behavioural cache/memory model.
module tb_l3_miss_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        l2_req_i = 1'b0;
  logic        l2_wr_en_i = 1'b0;
  logic [31:0] l2_addr_i = '0;
  logic [31:0] l2_wr_data_i = '0;
  logic [3:0]  l2_byte_en_i = '0;
  logic        l3_busy_o;
  logic        l3_cache_valid_o;
  logic [31:0] l3_cache_data_o;
  logic        mem_req_o;
  logic        mem_wr_en_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wr_data_o;
  logic        mem_ready_i = 1'b0;
  logic [31:0] mem_rd_data_i = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  l3_miss_responder dut (
    .clk(clk), .rst_n(rst_n),
    .l2_req_i(l2_req_i), .l2_wr_en_i(l2_wr_en_i), .l2_addr_i(l2_addr_i),
    .l2_wr_data_i(l2_wr_data_i), .l2_byte_en_i(l2_byte_en_i),
    .l3_busy_o(l3_busy_o), .l3_cache_valid_o(l3_cache_valid_o), .l3_cache_data_o(l3_cache_data_o),
    .mem_req_o(mem_req_o), .mem_wr_en_o(mem_wr_en_o), .mem_addr_o(mem_addr_o),
    .mem_wr_data_o(mem_wr_data_o), .mem_ready_i(mem_ready_i), .mem_rd_data_i(mem_rd_data_i)
  );

  // Physical memory served to the DUT, and the model's own view of memory/cache
  logic [31:0] phys_mem [logic [31:0]];
  logic [31:0] ref_mem  [logic [31:0]];
  bit          ref_valid [1024];
  logic [19:0] ref_tag   [1024];
  logic [31:0] ref_data  [1024];

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  function automatic logic [31:0] phys_word(input logic [31:0] a);
    return phys_mem.exists(a) ? phys_mem[a] : dflt(a);
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    phys_mem[a] = d;
    ref_mem[a]  = d;
  endtask

  // Reference: direct-mapped, write-allocate, write-through; latency is two
  // cycles plus one (wait+1) slot per memory handshake.
  task automatic model_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] be, input int wt,
                           output logic [31:0] e_resp, output int e_rd, output int e_wr,
                           output logic [31:0] e_wdata, output int e_lat);
    int          idx;
    logic [19:0] tg;
    logic [31:0] waddr, old, mask;
    bit          hit, be_ok;
    idx   = int'(addr[11:2]);
    tg    = addr[31:12];
    waddr = {addr[31:2], 2'b00};
    hit   = ref_valid[idx] && (ref_tag[idx] == tg);
    be_ok = (be == 4'h1) || (be == 4'h3) || (be == 4'hF);
    if (hit) old = ref_data[idx];
    else begin
      old = ref_word(waddr);
      ref_valid[idx] = 1'b1;
      ref_tag[idx]   = tg;
      ref_data[idx]  = old;
    end
    e_rd   = hit ? 0 : 1;
    e_wr   = (wr && be_ok) ? 1 : 0;
    e_resp = old;
    mask   = (be == 4'h1) ? 32'h0000_00FF : (be == 4'h3) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    e_wdata = (old & ~mask) | (wdata & mask);
    if (e_wr == 1) begin
      ref_data[idx]  = e_wdata;
      ref_mem[waddr] = e_wdata;
    end
    e_lat = 2 + (e_rd + e_wr) * (wt + 1);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    l2_req_i = 1'b0; l2_wr_en_i = 1'b0; l2_addr_i = '0; l2_wr_data_i = '0; l2_byte_en_i = '0;
    mem_ready_i = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 1024; i++) ref_valid[i] = 1'b0;
  endtask

  // Drives one L2 request and acts as main memory with wt wait cycles per handshake
  task automatic do_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input int wt, input bit hold,
                        output logic [31:0] resp, output int n_rd, output int n_wr,
                        output logic [31:0] rd_addr, output logic [31:0] wr_data,
                        output int lat, output int pulses, output bit stable, output bit timeout);
    int cyc, waited;
    bit fresh, done;
    logic [31:0] h_addr, h_data;
    logic h_we;
    n_rd = 0; n_wr = 0; pulses = 0; lat = -1; stable = 1'b1; timeout = 1'b0;
    resp = 'x; rd_addr = 'x; wr_data = 'x; h_addr = '0; h_data = '0; h_we = 1'b0;
    fresh = 1'b1; waited = 0; done = 1'b0; cyc = 0;
    @(negedge clk);
    l2_req_i = 1'b1; l2_wr_en_i = wr; l2_addr_i = addr; l2_wr_data_i = wdata; l2_byte_en_i = be;
    while (!done && cyc < 300) begin
      @(negedge clk);
      cyc++;
      mem_ready_i = 1'b0;
      if (!hold) l2_req_i = 1'b0;
      if (l3_cache_valid_o) begin
        pulses++;
        l2_req_i = 1'b0;
        if (lat < 0) begin lat = cyc; resp = l3_cache_data_o; end
      end else if (!l3_busy_o && lat >= 0) begin
        done = 1'b1;
      end
      if (mem_req_o) begin
        if (fresh) begin
          h_addr = mem_addr_o; h_we = mem_wr_en_o; h_data = mem_wr_data_o;
          fresh = 1'b0; waited = 0;
        end else if (mem_addr_o !== h_addr || mem_wr_en_o !== h_we || mem_wr_data_o !== h_data) begin
          stable = 1'b0;
        end
        if (waited == wt) begin
          mem_ready_i = 1'b1;
          fresh = 1'b1;
          if (mem_wr_en_o) begin
            n_wr++; wr_data = mem_wr_data_o; phys_mem[mem_addr_o] = mem_wr_data_o;
          end else begin
            n_rd++; rd_addr = mem_addr_o; mem_rd_data_i = phys_word(mem_addr_o);
          end
        end else begin
          waited++;
        end
      end
    end
    timeout = !done;
    mem_ready_i = 1'b0;
    l2_req_i = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    checks++; if (l3_busy_o !== 1'b0 || l3_cache_valid_o !== 1'b0)
      begin errors++; $display("FAIL reset_status: busy=%b valid=%b want 0 0", l3_busy_o, l3_cache_valid_o); end
    checks++; if (mem_req_o !== 1'b0 || mem_wr_en_o !== 1'b0)
      begin errors++; $display("FAIL reset_memctl: req=%b wr_en=%b want 0 0", mem_req_o, mem_wr_en_o); end
    checks++; if (l3_cache_data_o !== 32'h0)
      begin errors++; $display("FAIL reset_data: got %h want 0", l3_cache_data_o); end
    checks++; if (mem_addr_o !== 32'h0 || mem_wr_data_o !== 32'h0)
      begin errors++; $display("FAIL reset_memdata: addr=%h wdata=%h want 0 0", mem_addr_o, mem_wr_data_o); end
  endtask

  task automatic test_read_miss_hit();
    logic [31:0] resp, rd_addr, wr_data, e_resp, e_wdata;
    int n_rd, n_wr, lat, pulses, e_rd, e_wr, e_lat;
    bit stable, timeout;
    preload(32'h0000_1004, 32'hDEAD_BEEF);
    model_txn(1'b0, 32'h0000_1004, '0, 4'hF, 3, e_resp, e_rd, e_wr, e_wdata, e_lat);
    do_txn(1'b0, 32'h0000_1004, '0, 4'hF, 3, 1'b0, resp, n_rd, n_wr, rd_addr, wr_data, lat, pulses, stable, timeout);
    checks++; if (resp !== 32'hDEAD_BEEF)
      begin errors++; $display("FAIL rdmiss_data: got %h want deadbeef", resp); end
    checks++; if (n_rd !== 1 || n_wr !== 0 || rd_addr !== 32'h0000_1004)
      begin errors++; $display("FAIL rdmiss_mem: rd=%0d wr=%0d addr=%h want 1 0 00001004", n_rd, n_wr, rd_addr); end
    checks++; if (timeout || lat !== e_lat || pulses !== 1)
      begin errors++; $display("FAIL rdmiss_timing: lat=%0d pulses=%0d to=%0b want %0d 1 0", lat, pulses, timeout, e_lat); end
    model_txn(1'b0, 32'h0000_1004, '0, 4'hF, 3, e_resp, e_rd, e_wr, e_wdata, e_lat);
    do_txn(1'b0, 32'h0000_1004, '0, 4'hF, 3, 1'b0, resp, n_rd, n_wr, rd_addr, wr_data, lat, pulses, stable, timeout);
    checks++; if (n_rd !== 0 || n_wr !== 0)
      begin errors++; $display("FAIL rdhit_nomem: rd=%0d wr=%0d want 0 0", n_rd, n_wr); end
    checks++; if (timeout || lat !== 2)
      begin errors++; $display("FAIL rdhit_latency: got %0d want 2", lat); end
    checks++; if (resp !== 32'hDEAD_BEEF)
      begin errors++; $display("FAIL rdhit_data: got %h want deadbeef", resp); end
  endtask

  task automatic test_write_hit_byte();
    logic [31:0] resp, rd_addr, wr_data, e_resp, e_wdata;
    int n_rd, n_wr, lat, pulses, e_rd, e_wr, e_lat;
    bit stable, timeout;
    preload(32'h0000_3010, 32'h1122_3344);
    model_txn(1'b0, 32'h0000_3010, '0, 4'hF, 1, e_resp, e_rd, e_wr, e_wdata, e_lat);
    do_txn(1'b0, 32'h0000_3010, '0, 4'hF, 1, 1'b0, resp, n_rd, n_wr, rd_addr, wr_data, lat, pulses, stable, timeout);
    model_txn(1'b1, 32'h0000_3010, 32'h0000_00AA, 4'h1, 1, e_resp, e_rd, e_wr, e_wdata, e_lat);
    do_txn(1'b1, 32'h0000_3010, 32'h0000_00AA, 4'h1, 1, 1'b0, resp, n_rd, n_wr, rd_addr, wr_data, lat, pulses, stable, timeout);
    checks++; if (n_rd !== 0 || n_wr !== 1 || wr_data !== 32'h1122_33AA)
      begin errors++; $display("FAIL wrbyte_mem: rd=%0d wr=%0d data=%h want 0 1 112233aa", n_rd, n_wr, wr_data); end
    checks++; if (resp !== 32'h1122_3344)
      begin errors++; $display("FAIL wrbyte_resp: got %h want 11223344", resp); end
    checks++; if (timeout || lat !== e_lat)
      begin errors++; $display("FAIL wrbyte_latency: got %0d want %0d", lat, e_lat); end
    model_txn(1'b0, 32'h0000_3010, '0, 4'hF, 1, e_resp, e_rd, e_wr, e_wdata, e_lat);
    do_txn(1'b0, 32'h0000_3010, '0, 4'hF, 1, 1'b0, resp, n_rd, n_wr, rd_addr, wr_data, lat, pulses, stable, timeout);
    checks++; if (resp !== 32'h1122_33AA || n_rd !== 0)
      begin errors++; $display("FAIL wrbyte_readback: data=%h rd=%0d want 112233aa 0", resp, n_rd); end
  endtask

  task automatic test_write_miss_half();
    logic [31:0] resp, rd_addr, wr_data, e_resp, e_wdata;
    int n_rd, n_wr, lat, pulses, e_rd, e_wr, e_lat;
    bit stable, timeout;
    preload(32'h0000_2008, 32'h5566_7788);
    model_txn(1'b1, 32'h0000_2008, 32'h0000_BEEF, 4'h3, 2, e_resp, e_rd, e_wr, e_wdata, e_lat);
    do_txn(1'b1, 32'h0000_2008, 32'h0000_BEEF, 4'h3, 2, 1'b0, resp, n_rd, n_wr, rd_addr, wr_data, lat, pulses, stable, timeout);
    checks++; if (n_rd !== 1 || rd_addr !== 32'h0000_2008)
      begin errors++; $display("FAIL wrmiss_read: rd=%0d addr=%h want 1 00002008", n_rd, rd_addr); end
    checks++; if (n_wr !== 1 || wr_data !== 32'h5566_BEEF)
      begin errors++; $display("FAIL wrmiss_write: wr=%0d data=%h want 1 5566beef", n_wr, wr_data); end
    checks++; if (resp !== 32'h5566_7788)
      begin errors++; $display("FAIL wrmiss_resp: got %h want 55667788", resp); end
    checks++; if (timeout || lat !== 8 || !stable)
      begin errors++; $display("FAIL wrmiss_timing: lat=%0d stable=%0b want 8 1", lat, stable); end
  endtask

  task automatic test_conflict();
    logic [31:0] resp, rd_addr, wr_data, e_resp, e_wdata;
    logic [31:0] addrs [3];
    int n_rd, n_wr, lat, pulses, e_rd, e_wr, e_lat, total_rd;
    bit stable, timeout;
    addrs[0] = 32'h0000_1004; addrs[1] = 32'h0000_2004; addrs[2] = 32'h0000_1004;
    apply_reset();
    preload(32'h0000_2004, 32'hCAFE_0001);
    total_rd = 0;
    for (int i = 0; i < 3; i++) begin
      model_txn(1'b0, addrs[i], '0, 4'hF, 0, e_resp, e_rd, e_wr, e_wdata, e_lat);
      do_txn(1'b0, addrs[i], '0, 4'hF, 0, 1'b0, resp, n_rd, n_wr, rd_addr, wr_data, lat, pulses, stable, timeout);
      total_rd += n_rd;
      checks++; if (resp !== phys_word(addrs[i]) || timeout)
        begin errors++; $display("FAIL conflict_resp%0d: got %h want %h", i, resp, phys_word(addrs[i])); end
    end
    checks++; if (total_rd !== 3)
      begin errors++; $display("FAIL conflict_reads: got %0d want 3", total_rd); end
  endtask

  task automatic test_held_req();
    logic [31:0] resp, rd_addr, wr_data, e_resp, e_wdata;
    int n_rd, n_wr, lat, pulses, e_rd, e_wr, e_lat, extra;
    bit stable, timeout;
    model_txn(1'b0, 32'h0000_6000, '0, 4'hF, 5, e_resp, e_rd, e_wr, e_wdata, e_lat);
    do_txn(1'b0, 32'h0000_6000, '0, 4'hF, 5, 1'b1, resp, n_rd, n_wr, rd_addr, wr_data, lat, pulses, stable, timeout);
    extra = 0;
    repeat (3) begin @(negedge clk); if (l3_cache_valid_o || mem_req_o) extra++; end
    checks++; if (pulses !== 1 || extra !== 0 || n_rd !== 1)
      begin errors++; $display("FAIL held_single: pulses=%0d extra=%0d rd=%0d want 1 0 1", pulses, extra, n_rd); end
    checks++; if (!stable)
      begin errors++; $display("FAIL held_stable: mem outputs changed while waiting"); end
    checks++; if (timeout || lat !== 8 || resp !== e_resp)
      begin errors++; $display("FAIL held_resp: lat=%0d data=%h want 8 %h", lat, resp, e_resp); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] resp, rd_addr, wr_data, e_resp, e_wdata;
    int n_rd, n_wr, lat, pulses, e_rd, e_wr, e_lat, seen;
    bit stable, timeout;
    model_txn(1'b0, 32'h0000_4008, '0, 4'hF, 0, e_resp, e_rd, e_wr, e_wdata, e_lat);
    do_txn(1'b0, 32'h0000_4008, '0, 4'hF, 0, 1'b0, resp, n_rd, n_wr, rd_addr, wr_data, lat, pulses, stable, timeout);
    @(negedge clk);
    l2_req_i = 1'b1; l2_wr_en_i = 1'b0; l2_addr_i = 32'h0000_5008; l2_byte_en_i = 4'hF;
    @(negedge clk);
    l2_req_i = 1'b0;
    @(negedge clk);
    checks++; if (mem_req_o !== 1'b1)
      begin errors++; $display("FAIL rstmid_pre: mem_req=%b want 1", mem_req_o); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (mem_req_o !== 1'b0 || l3_busy_o !== 1'b0 || mem_addr_o !== 32'h0)
      begin errors++; $display("FAIL rstmid_drop: req=%b busy=%b addr=%h want 0 0 0", mem_req_o, l3_busy_o, mem_addr_o); end
    seen = 0;
    repeat (2) begin @(negedge clk); if (l3_cache_valid_o) seen++; end
    rst_n = 1'b1;
    for (int i = 0; i < 1024; i++) ref_valid[i] = 1'b0;
    repeat (3) begin @(negedge clk); if (l3_cache_valid_o || mem_req_o) seen++; end
    checks++; if (seen !== 0)
      begin errors++; $display("FAIL rstmid_nopulse: activity=%0d want 0", seen); end
    model_txn(1'b0, 32'h0000_4008, '0, 4'hF, 0, e_resp, e_rd, e_wr, e_wdata, e_lat);
    do_txn(1'b0, 32'h0000_4008, '0, 4'hF, 0, 1'b0, resp, n_rd, n_wr, rd_addr, wr_data, lat, pulses, stable, timeout);
    checks++; if (n_rd !== 1 || resp !== e_resp || timeout)
      begin errors++; $display("FAIL rstmid_miss: rd=%0d data=%h want 1 %h", n_rd, resp, e_resp); end
  endtask

  task automatic test_random();
    logic [31:0] resp, rd_addr, wr_data, e_resp, e_wdata, addr, wdata;
    logic [3:0] be;
    logic wr;
    int n_rd, n_wr, lat, pulses, e_rd, e_wr, e_lat, wt;
    bit stable, timeout;
    for (int i = 0; i < 60; i++) begin
      addr  = (32'($urandom_range(1, 4)) << 12) | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
      wr    = 1'($urandom_range(0, 1));
      wdata = $urandom;
      wt    = int'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0: be = 4'h1;
        1: be = 4'h3;
        2: be = 4'hF;
        default: be = 4'h5;
      endcase
      model_txn(wr, addr, wdata, be, wt, e_resp, e_rd, e_wr, e_wdata, e_lat);
      do_txn(wr, addr, wdata, be, wt, 1'b0, resp, n_rd, n_wr, rd_addr, wr_data, lat, pulses, stable, timeout);
      checks++; if (resp !== e_resp)
        begin errors++; $display("FAIL rand%0d_resp: got %h want %h", i, resp, e_resp); end
      checks++; if (n_rd !== e_rd || n_wr !== e_wr)
        begin errors++; $display("FAIL rand%0d_mem: rd=%0d wr=%0d want %0d %0d", i, n_rd, n_wr, e_rd, e_wr); end
      if (e_wr == 1) begin
        checks++; if (wr_data !== e_wdata)
          begin errors++; $display("FAIL rand%0d_wdata: got %h want %h", i, wr_data, e_wdata); end
      end
      checks++; if (timeout || lat !== e_lat || pulses !== 1 || !stable)
        begin errors++; $display("FAIL rand%0d_timing: lat=%0d pulses=%0d stable=%0b want %0d 1 1", i, lat, pulses, stable, e_lat); end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_read_miss_hit();
    test_write_hit_byte();
    test_write_miss_half();
    test_conflict();
    test_held_req();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
